// File: rtl/serial_paralelo_rx.sv
// Serial-to-byte receiver: finds COM (0xBC) alignment, then presents bytes.
// Optional SYNC_LOSS_EN: too many data bytes without COM drops back to SEARCH.
module serial_paralelo_rx #(
  parameter logic [7:0]  COM_SYMBOL   = 8'hBC,
  parameter int unsigned BC_COUNT     = 4,
  parameter int unsigned MAX_DATA_RUN = 64
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic       idle
);

  typedef enum logic [1:0] {
    S_SEARCH,
    S_SYNC,
    S_ACTIVE
  } state_t;

  state_t     state, state_n;
  logic [7:0] sr;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [3:0] bc_cnt, bc_cnt_n;
  logic [7:0] data_n;
  logic       valid_n, idle_n;
  logic       is_com, boundary, bc_done, drop;

  if (BC_COUNT < 2 || BC_COUNT > 15) begin : g_bad_bc
    $error("BC_COUNT out of range 2..15");
  end
  if (MAX_DATA_RUN < 1 || MAX_DATA_RUN > 255) begin : g_bad_run
    $error("MAX_DATA_RUN out of range 1..255");
  end

  assign is_com   = (sr == COM_SYMBOL);
  assign boundary = (bit_cnt == 3'd0) && (state != S_SEARCH);
  assign bc_done  = (({1'b0, bc_cnt} + 5'd1) == 5'(BC_COUNT));

`ifdef SYNC_LOSS_EN
  logic [7:0] run_cnt, run_cnt_n;

  assign drop = boundary && (state == S_ACTIVE) && !is_com &&
                (({1'b0, run_cnt} + 9'd1) > 9'(MAX_DATA_RUN));

  always_comb begin
    run_cnt_n = run_cnt;
    if (state != S_ACTIVE || drop)
      run_cnt_n = '0;
    else if (boundary)
      run_cnt_n = is_com ? 8'd0 : run_cnt + 8'd1;
  end

  always_ff @(posedge clk_32f) begin
    if (reset) run_cnt <= '0;
    else       run_cnt <= run_cnt_n;
  end
`else
  assign drop = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt + 3'd1;
    bc_cnt_n  = bc_cnt;
    unique case (state)
      S_SEARCH: begin
        bit_cnt_n = 3'd0;
        // sr already holds the first COM, so the next boundary is 8 edges on
        if (is_com) begin
          state_n   = S_SYNC;
          bit_cnt_n = 3'd1;
          bc_cnt_n  = 4'd1;
        end
      end
      S_SYNC: begin
        if (boundary && !is_com) begin
          state_n   = S_SEARCH;
          bit_cnt_n = 3'd0;
          bc_cnt_n  = 4'd0;
        end else if (boundary) begin
          if (bc_cnt != 4'hF) bc_cnt_n = bc_cnt + 4'd1;
          if (bc_done) state_n = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (drop) begin
          state_n   = S_SEARCH;
          bit_cnt_n = 3'd0;
          bc_cnt_n  = 4'd0;
        end
      end
      default: state_n = S_SEARCH;
    endcase
  end

  always_comb begin
    data_n  = data_out;
    valid_n = 1'b0;
    idle_n  = 1'b0;
    if (state == S_ACTIVE && !drop) begin
      valid_n = valid_out;
      idle_n  = idle;
      if (boundary) begin
        data_n  = sr;
        valid_n = !is_com;
        idle_n  = is_com;
      end
    end
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state     <= S_SEARCH;
      sr        <= '0;
      bit_cnt   <= '0;
      bc_cnt    <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      idle      <= 1'b0;
      active    <= 1'b0;
    end else begin
      state     <= state_n;
      sr        <= {sr[6:0], data_in};
      bit_cnt   <= bit_cnt_n;
      bc_cnt    <= bc_cnt_n;
      data_out  <= data_n;
      valid_out <= valid_n;
      idle      <= idle_n;
      active    <= (state_n == S_ACTIVE);
    end
  end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Bench for serial_paralelo_rx: directed byte tables plus random stream
// compared every cycle against a byte-level reference model.
module tb_serial_paralelo_rx;

  localparam logic [7:0] COM = 8'hBC;
  localparam int BCN = 4;
  localparam int MDR = 4;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b1;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out, active, idle;

  int total = 0;
  int bad   = 0;

  serial_paralelo_rx #(
    .COM_SYMBOL(COM),
    .BC_COUNT(BCN),
    .MAX_DATA_RUN(MDR)
  ) dut (
    .clk_32f(clk_32f),
    .reset(reset),
    .data_in(data_in),
    .data_out(data_out),
    .valid_out(valid_out),
    .active(active),
    .idle(idle)
  );

  always #5 clk_32f = ~clk_32f;

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // reference model: 0=searching, 1=counting COMs, 2=linked
  int         m_hist = 0;
  int         m_mode = 0;
  int         m_count = 0;
  int         m_run = 0;
  longint     m_edge = 0;
  longint     m_anchor = 0;
  logic [7:0] e_data = 8'h00;
  logic       e_valid = 1'b0;
  logic       e_idle = 1'b0;
  logic       e_active = 1'b0;

  logic [7:0] sf_data, sl_data;
  logic       sf_valid, sf_idle, sf_active;
  logic       sl_valid, sl_idle, sl_active;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_idle;
  } vec_t;
  vec_t vt[4];

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_edge(input logic b, input logic r);
    int w;
    bit on_byte;
    m_edge++;
    if (r) begin
      m_hist = 0; m_mode = 0; m_count = 0; m_run = 0;
      e_data = 8'h00; e_valid = 0; e_idle = 0; e_active = 0;
      return;
    end
    w = m_hist;
    on_byte = (m_mode != 0) && ((m_edge - m_anchor) % 8 == 0);
    if (m_mode == 0) begin
      if (w == int'(COM)) begin
        m_mode = 1; m_anchor = m_edge; m_count = 1;
      end
    end else if (m_mode == 1 && on_byte) begin
      if (w == int'(COM)) begin
        m_count++;
        if (m_count == BCN) m_mode = 2;
      end else begin
        m_mode = 0; m_count = 0;
      end
    end else if (m_mode == 2 && on_byte) begin
`ifdef SYNC_LOSS_EN
      if (w != int'(COM) && m_run + 1 > MDR) begin
        m_mode = 0; m_count = 0; m_run = 0;
        e_valid = 0; e_idle = 0;
      end else
`endif
      begin
        e_data  = w[7:0];
        e_valid = (w != int'(COM));
        e_idle  = (w == int'(COM));
        m_run   = (w == int'(COM)) ? 0 : m_run + 1;
      end
    end
    e_active = (m_mode == 2);
    m_hist = (m_hist * 2 + int'(b)) % 256;
  endtask

  task automatic tick(input logic b, input logic r);
    data_in = b;
    reset   = r;
    @(posedge clk_32f);
    model_edge(b, r);
    @(negedge clk_32f);
    chk("model", {5'd0, data_out, valid_out, idle, active},
        {5'd0, e_data, e_valid, e_idle, e_active});
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      tick(v[i], 1'b0);
      if (i == 7) begin
        sf_data = data_out; sf_valid = valid_out;
        sf_idle = idle; sf_active = active;
      end
    end
    sl_data = data_out; sl_valid = valid_out;
    sl_idle = idle; sl_active = active;
  endtask

  task automatic sync_up();
    tick(1'b0, 1'b1);
    for (int i = 0; i < BCN; i++) send_byte(COM);
  endtask

  initial begin
    logic [7:0] nx;
    int r;

    vt[0] = '{8'h11, 8'h11, 1'b1, 1'b0};
    vt[1] = '{8'h22, 8'h22, 1'b1, 1'b0};
    vt[2] = '{8'hBC, 8'hBC, 1'b0, 1'b1};
    vt[3] = '{8'hFF, 8'hFF, 1'b1, 1'b0};

    // reset, then continuous COM stream
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    chk("reset_state", {5'd0, data_out, valid_out, idle, active}, 16'd0);
    for (int i = 0; i < BCN; i++) send_byte(COM);
    chk("t1_active_early", {15'd0, sl_active}, 16'd0);
    send_byte(COM);
    chk("t1_active_rise", {15'd0, sf_active}, 16'd1);
    chk("t1_idle_before", {15'd0, sf_idle}, 16'd0);
    send_byte(COM);
    chk("t1_first_byte", {7'd0, sf_data, sf_valid, sf_idle},
        {7'd0, COM, 1'b0, 1'b1});

    // data bytes through the linked receiver
    send_byte(vt[0].tx);
    chk("t2_latency", {15'd0, sl_valid}, 16'd0);
    for (int i = 0; i < 4; i++) begin
      nx = COM;
      if (i < 3) nx = vt[i + 1].tx;
      send_byte(nx);
      chk($sformatf("t2_first_%0d", i), {6'd0, sf_data, sf_valid, sf_idle},
          {6'd0, vt[i].exp_data, vt[i].exp_valid, vt[i].exp_idle});
      chk($sformatf("t2_held_%0d", i), {6'd0, sl_data, sl_valid, sl_idle},
          {6'd0, vt[i].exp_data, vt[i].exp_valid, vt[i].exp_idle});
    end

    // a non-COM during sync restarts the count
    tick(1'b0, 1'b1);
    send_byte(COM); send_byte(COM); send_byte(8'h55);
    for (int i = 0; i < 3; i++) send_byte(COM);
    chk("t3_after3", {15'd0, sl_active}, 16'd0);
    send_byte(COM);
    chk("t3_after4", {15'd0, sl_active}, 16'd0);
    send_byte(COM);
    chk("t3_rise", {15'd0, sf_active}, 16'd1);

    // reset pulse in the middle of a byte
    sync_up();
    send_byte(COM); send_byte(8'h3C); send_byte(8'h5A);
    chk("t4_flowing", {6'd0, sl_data, sl_valid, sl_active},
        {6'd0, 8'h3C, 1'b1, 1'b1});
    tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    chk("t4_reset", {5'd0, data_out, valid_out, idle, active}, 16'd0);
    for (int i = 0; i < BCN; i++) send_byte(COM);
    chk("t4_not_yet", {15'd0, sl_active}, 16'd0);
    send_byte(COM);
    chk("t4_resync", {15'd0, sf_active}, 16'd1);

    // junk bits ahead of the stream shift the alignment
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b1, 1'b0);
    for (int i = 0; i < BCN; i++) send_byte(COM);
    send_byte(8'h5A);
    chk("t5_active", {15'd0, sf_active}, 16'd1);
    send_byte(8'hC3);
    chk("t5_byte0", {7'd0, sf_data, sf_valid}, {7'd0, 8'h5A, 1'b1});
    send_byte(COM);
    chk("t5_byte1", {7'd0, sf_data, sf_valid}, {7'd0, 8'hC3, 1'b1});

`ifdef SYNC_LOSS_EN
    // run of data bytes longer than the limit
    sync_up();
    for (int i = 0; i < 5; i++) begin
      send_byte(8'hA5);
      if (i >= 1)
        chk($sformatf("t6_valid_%0d", i), {7'd0, sf_data, sf_valid},
            {7'd0, 8'hA5, 1'b1});
    end
    send_byte(COM);
    chk("t6_drop", {6'd0, sf_data, sf_valid, sf_active},
        {6'd0, 8'hA5, 1'b0, 1'b0});
`endif

    // random stream against the model
    tick(1'b0, 1'b1);
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(99));
      if (r < 3) begin
        tick(1'($urandom_range(1)), 1'b1);
      end else if (r < 8) begin
        for (int k = 0; k < int'($urandom_range(7, 1)); k++)
          tick(1'($urandom_range(1)), 1'b0);
      end else if (r < 55) begin
        send_byte(COM);
      end else begin
        send_byte(8'($urandom_range(255)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
